systolic_skew_buffer: RTL and testbench

- Parametrised per-lane delay (skew) buffer feeding the row/column edge of the systolic array.
- Lane i gets a programmable staircase delay, giving the diagonal wavefront the PE grid needs.
- Runtime mode selects skew (ascending delay) for array inputs or deskew (descending delay) for realigning array outputs.
- Adds a global clock-enable stall, per-lane valid tracking with zero-filled bubbles, a last-beat tag and a busy/drain indicator.

---
 rtl/systolic_skew_buffer.sv | 83 ++++++++
 tb/tb_systolic_skew_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_buffer.sv
// Per-lane staircase delay buffer for the systolic array edge.
// Skew mode gives lane i a delay of BASE_DELAY+i cycles and deskew mode gives
// BASE_DELAY+LANES-1-i. Every lane shares one shift chain of depth
// BASE_DELAY+LANES-1, and each lane taps that chain at a fixed, mode-selected
// stage, so no output depends combinationally on din.
module systolic_skew_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  parameter int BASE_DELAY = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ce,
  input  logic                        mode_in,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [DATA_WIDTH*LANES-1:0] din,
  output logic [DATA_WIDTH*LANES-1:0] dout,
  output logic [LANES-1:0]            out_valid,
  output logic                        out_last,
  output logic                        mode,
  output logic                        busy
);

  localparam int DEPTH = BASE_DELAY + LANES - 1;

  // Stage j holds whatever beat was sampled j+1 enabled edges ago.
  logic [DATA_WIDTH*LANES-1:0] r_data [DEPTH];
  // Every lane loads the same in_valid, so a single valid chain serves all lanes.
  logic [DEPTH-1:0]            r_vld;
  logic [DEPTH-1:0]            r_last;
  logic                        r_mode;
  logic                        w_busy;

  // Shift the data, valid and last chains on every enabled edge.
  // A bubble loads zero data so idle lanes always present zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_data[j] <= '0;
      end
      r_vld  <= '0;
      r_last <= '0;
    end else if (ce) begin
      r_data[0] <= in_valid ? din : '0;
      for (int j = 1; j < DEPTH; j++) begin
        r_data[j] <= r_data[j-1];
      end
      r_vld  <= {r_vld[DEPTH-2:0], in_valid};
      r_last <= {r_last[DEPTH-2:0], in_valid & in_last};
    end
  end

  assign w_busy = |r_vld;

  // Mode changes only while the pipe is empty and no beat is entering.
  // This keeps the tap selection fixed for every beat already in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode <= 1'b0;
    end else if (ce && !w_busy && !in_valid) begin
      r_mode <= mode_in;
    end
  end

  // Fixed per-lane taps: the skew tap index rises with the lane number,
  // and the deskew tap index falls with it.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int SKEW_TAP   = BASE_DELAY - 1 + g;
    localparam int DESKEW_TAP = BASE_DELAY + LANES - 2 - g;

    assign dout[DATA_WIDTH*g +: DATA_WIDTH] =
        r_mode ? r_data[DESKEW_TAP][DATA_WIDTH*g +: DATA_WIDTH]
               : r_data[SKEW_TAP][DATA_WIDTH*g +: DATA_WIDTH];
    assign out_valid[g] = r_mode ? r_vld[DESKEW_TAP] : r_vld[SKEW_TAP];
  end

  // The last tag leaves with the lane that has the longest delay in either mode.
  assign out_last = r_last[DEPTH-1];
  assign mode     = r_mode;
  assign busy     = w_busy;

endmodule

// File: tb/tb_systolic_skew_buffer.sv
module tb_systolic_skew_buffer;

  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        rstn, ce, mode_in, in_valid, in_last;
  logic [31:0] din, dout;
  logic [3:0]  out_valid;
  logic        out_last, mode, busy;

  logic        in_valid2, in_last2, mode_in2;
  logic [31:0] din2, dout2;
  logic [3:0]  out_valid2;
  logic        out_last2, mode2, busy2;

  always #5 clk = ~clk;

  systolic_skew_buffer #(.DATA_WIDTH(8), .LANES(4), .BASE_DELAY(1)) u_dut (
    .clk(clk), .rstn(rstn), .ce(ce), .mode_in(mode_in), .in_valid(in_valid),
    .in_last(in_last), .din(din), .dout(dout), .out_valid(out_valid),
    .out_last(out_last), .mode(mode), .busy(busy)
  );

  systolic_skew_buffer #(.DATA_WIDTH(8), .LANES(4), .BASE_DELAY(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .ce(ce), .mode_in(mode_in2), .in_valid(in_valid2),
    .in_last(in_last2), .din(din2), .dout(dout2), .out_valid(out_valid2),
    .out_last(out_last2), .mode(mode2), .busy(busy2)
  );

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic        chk_last;
    int unsigned due;
  } exp_t;

  exp_t        sb [NL][$];
  exp_t        mon_e;
  int unsigned ecnt = 0;
  bit          en_edge = 1'b0;
  bit          m_mode = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_d2 [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Bench's own count of enabled edges; lane due times are measured in it.
  always @(posedge clk) begin
    en_edge = rstn && ce;
    if (rstn && ce) ecnt++;
  end

  // Monitor: after each enabled edge, pop and compare every presenting lane.
  always @(negedge clk) begin
    if (en_edge) begin
      for (int i = 0; i < NL; i++) begin
        if (out_valid[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("unexpected_valid_l%0d", i), {31'd0, out_valid[i]}, 32'd0);
          end else begin
            mon_e = sb[i].pop_front();
            check($sformatf("data_l%0d", i), {24'd0, dout[8*i +: 8]}, {24'd0, mon_e.data});
            check($sformatf("latency_l%0d", i), ecnt, mon_e.due);
            if (mon_e.chk_last)
              check($sformatf("last_l%0d", i), {31'd0, out_last}, {31'd0, mon_e.last});
          end
        end else begin
          check($sformatf("bubble_zero_l%0d", i), {24'd0, dout[8*i +: 8]}, 32'd0);
          if (sb[i].size() > 0 && sb[i][0].due <= ecnt) begin
            check($sformatf("missing_valid_l%0d", i), {31'd0, out_valid[i]}, 32'd1);
            void'(sb[i].pop_front());
          end
        end
      end
      if (out_last && out_valid == 4'd0) check("stray_last", {31'd0, out_last}, 32'd0);
    end
  end

  // Drive one beat (call just after a negedge) and queue the expected lane outputs.
  task automatic send(input logic [31:0] d, input bit last);
    exp_t e;
    in_valid = 1'b1;
    in_last  = last;
    din      = d;
    for (int i = 0; i < NL; i++) begin
      e.data     = d[8*i +: 8];
      e.last     = last;
      e.chk_last = m_mode ? (i == 0) : (i == NL - 1);
      e.due      = ecnt + (m_mode ? unsigned'(NL - i) : unsigned'(1 + i));
      sb[i].push_back(e);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NL; i++) sb[i].delete();
  endtask

  // Wait for the scoreboard to empty, bounded.
  task automatic drain();
    int left;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      left = 0;
      for (int i = 0; i < NL; i++) left += sb[i].size();
      if (left == 0) return;
    end
    check("drain_timeout", left, 32'd0);
    flush();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    exp_d2[0] = 32'h0;        exp_d2[1] = 32'h11;       exp_d2[2] = 32'h2200;
    exp_d2[3] = 32'h330000;   exp_d2[4] = 32'h44000000; exp_d2[5] = 32'h0;
    rstn = 1'b0; ce = 1'b1; mode_in = 1'b0; in_valid = 1'b0; in_last = 1'b0; din = '0;
    in_valid2 = 1'b0; in_last2 = 1'b1; mode_in2 = 1'b0; din2 = '0;

    #12;
    check("reset_dout", dout, 32'd0);
    check("reset_valid", {28'd0, out_valid}, 32'd0);
    check("reset_last", {31'd0, out_last}, 32'd0);
    check("reset_mode", {31'd0, mode}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Skew single beat with last tag.
    @(negedge clk); send(32'h44332211, 1'b1);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    check("busy_after_first", {31'd0, busy}, 32'd1);
    drain();
    @(negedge clk); check("busy_idle", {31'd0, busy}, 32'd0);

    // Deskew: one idle edge loads the mode.
    mode_in = 1'b1;
    @(negedge clk); check("mode_deskew", {31'd0, mode}, 32'd1);
    m_mode = 1'b1;
    send(32'h88776655, 1'b1);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    drain();
    mode_in = 1'b0;
    repeat (2) @(negedge clk);
    check("mode_back_skew", {31'd0, mode}, 32'd0);
    m_mode = 1'b0;

    // Stream A, B, bubble, C.
    @(negedge clk); send(32'hA4A3A2A1, 1'b0);
    @(negedge clk); send(32'hB4B3B2B1, 1'b0);
    @(negedge clk); in_valid = 1'b0; din = 32'hFFFFFFFF;
    @(negedge clk); send(32'hC4C3C2C1, 1'b1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0) begin in_valid = 1'b0; in_last = 1'b0; end
      check($sformatf("busy_stream_%0d", j), {31'd0, busy}, (j < 4) ? 32'd1 : 32'd0);
    end

    // Stall for three cycles with lane 1 presenting; a beat offered during the stall is dropped.
    @(negedge clk); send(32'hD4D3D2D1, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); ce = 1'b0; in_valid = 1'b1; din = 32'hDEADBEEF;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("stall_valid", {28'd0, out_valid}, 32'h2);
      check("stall_dout", dout, 32'h0000D200);
      check("stall_busy", {31'd0, busy}, 32'd1);
    end
    ce = 1'b1; in_valid = 1'b0; din = '0;
    drain();

    // Mode request while busy waits for the pipe to empty.
    repeat (2) @(negedge clk);
    send(32'hE4E3E2E1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) begin in_valid = 1'b0; mode_in = 1'b1; end
      check($sformatf("mode_wait_%0d", j), {31'd0, mode}, (j == 5) ? 32'd1 : 32'd0);
    end
    m_mode = 1'b1;

    // A beat entering alongside a mode request blocks the update and uses the old mode.
    @(negedge clk); mode_in = 1'b0; send(32'hF4F3F2F1, 1'b1);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    check("mode_blocked_by_beat", {31'd0, mode}, 32'd1);
    drain();
    repeat (2) @(negedge clk);
    check("mode_after_block", {31'd0, mode}, 32'd0);
    m_mode = 1'b0;

    // Async reset with deskew beats in flight.
    mode_in = 1'b1;
    @(negedge clk); m_mode = 1'b1; send(32'h17161514, 1'b1);
    @(negedge clk); send(32'h27262524, 1'b0);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0; mode_in = 1'b0;
    @(posedge clk); #2 rstn = 1'b0;
    #1;
    check("arst_dout", dout, 32'd0);
    check("arst_valid", {28'd0, out_valid}, 32'd0);
    check("arst_last", {31'd0, out_last}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_mode", {31'd0, mode}, 32'd0);
    flush();
    m_mode = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_valid", {28'd0, out_valid}, 32'd0);
    check("post_reset_mode", {31'd0, mode}, 32'd0);

    // BASE_DELAY=2 instance: lane i delay = 2+i, last after 5.
    @(negedge clk); in_valid2 = 1'b1; din2 = 32'h44332211;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 1) in_valid2 = 1'b0;
      check($sformatf("bd2_valid_%0d", j), {28'd0, out_valid2},
            (j >= 2 && j <= 5) ? (32'd1 << (j - 2)) : 32'd0);
      check($sformatf("bd2_dout_%0d", j), dout2, exp_d2[j-1]);
      check($sformatf("bd2_last_%0d", j), {31'd0, out_last2}, (j == 5) ? 32'd1 : 32'd0);
    end
    check("bd2_busy_idle", {31'd0, busy2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
